branch_predict_ctrl: RTL and testbench

- Sits between ID and EX.
- In ID, it predicts the direction of each beq/bne from a table of 2-bit saturating counters indexed by PC.
- In EX, it checks the prediction against the resolved branch outcome and raises the misprediction/flush and redirect-PC signals.
- It trains the table and keeps saturating branch/misprediction performance counters.

---
 rtl/branch_predict_ctrl_pkg.sv | 14 +
 rtl/branch_predict_ctrl_sat_counter2.sv | 22 ++
 rtl/branch_predict_ctrl.sv | 55 +++++
 tb/tb_branch_predict_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/branch_predict_ctrl_pkg.sv
// branch_predict_ctrl_pkg: opcode constants and 2-bit predictor counter encodings.
package branch_predict_ctrl_pkg;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;
    localparam ctr_t CTR_RESET = WNT;
endpackage

// File: rtl/branch_predict_ctrl_sat_counter2.sv
// sat_counter2: one 2-bit saturating up/down predictor counter; taken is the MSB.
module sat_counter2
    import branch_predict_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic up,
    output logic taken
);
    ctr_t cnt_q, cnt_d;
    always_comb begin
        cnt_d = cnt_q;
        if (en)
            cnt_d = up ? ((cnt_q == ST) ? ST : ctr_t'(cnt_q + 2'd1))
                       : ((cnt_q == SNT) ? SNT : ctr_t'(cnt_q - 2'd1));
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= CTR_RESET;
        else     cnt_q <= cnt_d;
    assign taken = cnt_q[1];
endmodule

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: bimodal beq/bne predictor between ID and EX with
// misprediction/redirect generation, table training and saturating perf counters.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ID_pc,
    input  logic        ID_is_branch,
    output logic        predicted,
    input  logic [31:0] EX_pc,
    input  logic        EX_is_branch,
    input  logic        EX_predicted,
    input  logic        BranchDecision,
    input  logic [31:0] EX_target,
    output logic        Wrong_prediction,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);
    localparam int DEPTH = 1 << INDEX_BITS;
    logic [DEPTH-1:0] taken;
    logic [31:0] branch_count_q, branch_count_d, mispredict_count_q, mispredict_count_d;
    logic unused_id_pc;
    for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
        sat_counter2 u_ctr (
            .clk   (clk),
            .rst   (rst),
            .en    (EX_is_branch && EX_pc[INDEX_BITS-1:0] == INDEX_BITS'(i)),
            .up    (BranchDecision),
            .taken (taken[i])
        );
    end
    assign unused_id_pc = ^ID_pc[31:INDEX_BITS];
    // Reads see the pre-edge table; updates land on the next clock.
    assign predicted        = ID_is_branch & ~rst & taken[ID_pc[INDEX_BITS-1:0]];
    assign Wrong_prediction = ~rst & EX_is_branch & (BranchDecision ^ EX_predicted);
    assign redirect_pc      = BranchDecision ? EX_target : EX_pc + 32'd1;
    always_comb begin
        branch_count_d     = (EX_is_branch && branch_count_q != '1) ? branch_count_q + 32'd1 : branch_count_q;
        mispredict_count_d = (Wrong_prediction && mispredict_count_q != '1) ? mispredict_count_q + 32'd1 : mispredict_count_q;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: directed scenario tasks with hand-computed expectations
// for prediction, misprediction/redirect, training, aliasing and async reset.
module tb_branch_predict_ctrl;
    logic        clk = 0;
    logic        rst;
    logic [31:0] ID_pc, EX_pc, EX_target;
    logic        ID_is_branch, EX_is_branch, EX_predicted, BranchDecision;
    logic        predicted, Wrong_prediction;
    logic [31:0] redirect_pc, branch_count, mispredict_count;
    int n_cmp = 0;
    int n_err = 0;

    branch_predict_ctrl #(.INDEX_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .ID_pc(ID_pc), .ID_is_branch(ID_is_branch), .predicted(predicted),
        .EX_pc(EX_pc), .EX_is_branch(EX_is_branch), .EX_predicted(EX_predicted),
        .BranchDecision(BranchDecision), .EX_target(EX_target),
        .Wrong_prediction(Wrong_prediction), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic [31:0] pc, input logic br, input logic tk, input logic pr, input logic [31:0] tgt);
        EX_pc = pc; EX_is_branch = br; BranchDecision = tk; EX_predicted = pr; EX_target = tgt;
        #1;
    endtask

    task automatic test_reset();
        rst = 1; ID_pc = 5; ID_is_branch = 1;
        ex(32'd9, 1, 1, 0, 32'h40);
        tick();
        n_cmp++; if (predicted !== 1'b0) begin n_err++; $display("FAIL rst_pred got %b want 0", predicted); end
        n_cmp++; if (Wrong_prediction !== 1'b0) begin n_err++; $display("FAIL rst_wp got %b want 0", Wrong_prediction); end
        n_cmp++; if (redirect_pc !== 32'h40) begin n_err++; $display("FAIL rst_redir got %h want 00000040", redirect_pc); end
        ex(32'd9, 1, 0, 0, 32'h40);
        n_cmp++; if (redirect_pc !== 32'd10) begin n_err++; $display("FAIL rst_redir_nt got %h want 0000000a", redirect_pc); end
        n_cmp++; if (branch_count !== 0 || mispredict_count !== 0) begin n_err++; $display("FAIL rst_cnt got %0d/%0d want 0/0", branch_count, mispredict_count); end
        ex(32'd9, 0, 0, 0, 32'h40);
        rst = 0; #1;
        n_cmp++; if (predicted !== 1'b0) begin n_err++; $display("FAIL init_pred5 got %b want 0", predicted); end
    endtask

    task automatic test_mispredict();
        ID_pc = 5; ID_is_branch = 1;
        ex(32'd5, 1, 1, 0, 32'h40);
        n_cmp++; if (Wrong_prediction !== 1'b1) begin n_err++; $display("FAIL mp_wp got %b want 1", Wrong_prediction); end
        n_cmp++; if (redirect_pc !== 32'h40) begin n_err++; $display("FAIL mp_redir got %h want 00000040", redirect_pc); end
        n_cmp++; if (predicted !== 1'b0) begin n_err++; $display("FAIL mp_pred_old got %b want 0", predicted); end
        tick();
        ex(32'd5, 0, 0, 0, 32'h40);
        n_cmp++; if (predicted !== 1'b1) begin n_err++; $display("FAIL mp_pred_new got %b want 1", predicted); end
        n_cmp++; if (branch_count !== 1 || mispredict_count !== 1) begin n_err++; $display("FAIL mp_cnt got %0d/%0d want 1/1", branch_count, mispredict_count); end
        ID_is_branch = 0; #1;
        n_cmp++; if (predicted !== 1'b0) begin n_err++; $display("FAIL nonbr_pred got %b want 0", predicted); end
    endtask

    task automatic test_train_saturate();
        logic [4:0] tk_seq;
        logic [4:0] pred_seq;
        tk_seq   = 5'b11000;
        pred_seq = 5'b00000;
        ID_pc = 3; ID_is_branch = 1;
        for (int k = 0; k < 5; k++) begin
            ex(32'd3, 1, tk_seq[k], 0, 32'h80);
            n_cmp++; if (predicted !== pred_seq[k]) begin n_err++; $display("FAIL sat_pred%0d got %b want %b", k, predicted, pred_seq[k]); end
            n_cmp++; if (Wrong_prediction !== tk_seq[k]) begin n_err++; $display("FAIL sat_wp%0d got %b want %b", k, Wrong_prediction, tk_seq[k]); end
            tick();
        end
        ex(32'd3, 0, 0, 0, 32'h80);
        n_cmp++; if (predicted !== 1'b1) begin n_err++; $display("FAIL sat_pred_final got %b want 1", predicted); end
        n_cmp++; if (branch_count !== 6 || mispredict_count !== 3) begin n_err++; $display("FAIL sat_cnt got %0d/%0d want 6/3", branch_count, mispredict_count); end
    endtask

    task automatic test_redirect();
        ID_is_branch = 0;
        ex(32'd7, 1, 0, 1, 32'h123);
        n_cmp++; if (Wrong_prediction !== 1'b1) begin n_err++; $display("FAIL rd_wp got %b want 1", Wrong_prediction); end
        n_cmp++; if (redirect_pc !== 32'd8) begin n_err++; $display("FAIL rd_pc7 got %h want 00000008", redirect_pc); end
        ex(32'hFFFFFFFF, 1, 0, 1, 32'h123);
        n_cmp++; if (redirect_pc !== 32'd0) begin n_err++; $display("FAIL rd_wrap got %h want 00000000", redirect_pc); end
        ex(32'hFFFFFFFF, 0, 0, 1, 32'h123);
        n_cmp++; if (Wrong_prediction !== 1'b0) begin n_err++; $display("FAIL rd_nonbr_wp got %b want 0", Wrong_prediction); end
        ex(32'hFFFFFFFF, 1, 0, 1, 32'h123);
        tick();
        ex(32'd0, 0, 0, 0, 32'h0);
        n_cmp++; if (branch_count !== 7 || mispredict_count !== 4) begin n_err++; $display("FAIL rd_cnt got %0d/%0d want 7/4", branch_count, mispredict_count); end
    endtask

    task automatic test_alias();
        ID_pc = 5; ID_is_branch = 1;
        ex(32'd5, 1, 0, 1, 32'h40);
        tick();
        ex(32'd21, 1, 1, 0, 32'h200);
        n_cmp++; if (predicted !== 1'b0) begin n_err++; $display("FAIL alias_old got %b want 0", predicted); end
        n_cmp++; if (redirect_pc !== 32'h200) begin n_err++; $display("FAIL alias_redir got %h want 00000200", redirect_pc); end
        tick();
        ex(32'd0, 0, 0, 0, 32'h0);
        n_cmp++; if (predicted !== 1'b1) begin n_err++; $display("FAIL alias_new got %b want 1", predicted); end
        n_cmp++; if (branch_count !== 9 || mispredict_count !== 6) begin n_err++; $display("FAIL alias_cnt got %0d/%0d want 9/6", branch_count, mispredict_count); end
    endtask

    task automatic test_reset_mid();
        ID_pc = 5; ID_is_branch = 1;
        ex(32'd5, 1, 0, 1, 32'h40);
        rst = 1; #1;
        n_cmp++; if (branch_count !== 0 || mispredict_count !== 0) begin n_err++; $display("FAIL mid_cnt got %0d/%0d want 0/0", branch_count, mispredict_count); end
        n_cmp++; if (predicted !== 1'b0 || Wrong_prediction !== 1'b0) begin n_err++; $display("FAIL mid_out got %b/%b want 0/0", predicted, Wrong_prediction); end
        tick();
        ex(32'd0, 0, 0, 0, 32'h0);
        rst = 0; #1;
        n_cmp++; if (predicted !== 1'b0) begin n_err++; $display("FAIL mid_pred5 got %b want 0", predicted); end
        ID_pc = 3; #1;
        n_cmp++; if (predicted !== 1'b0) begin n_err++; $display("FAIL mid_pred3 got %b want 0", predicted); end
        n_cmp++; if (branch_count !== 0 || mispredict_count !== 0) begin n_err++; $display("FAIL mid_cnt_after got %0d/%0d want 0/0", branch_count, mispredict_count); end
        ex(32'd3, 1, 1, 0, 32'h0);
        tick();
        ex(32'd0, 0, 0, 0, 32'h0);
        n_cmp++; if (predicted !== 1'b1 || branch_count !== 1) begin n_err++; $display("FAIL mid_retrain got %b/%0d want 1/1", predicted, branch_count); end
    endtask

    initial begin
        rst = 1; ID_pc = 0; ID_is_branch = 0;
        ex(32'd0, 0, 0, 0, 32'h0);
        test_reset();
        test_mispredict();
        test_train_saturate();
        test_redirect();
        test_alias();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
